// File: rtl/trace_pkg.sv
// Shared definitions for the trace capture block: record layout, widths and
// field positions. Constants are given for the default 32-bit data width;
// rec_width() gives the record width for any data width.
package trace_pkg;

    localparam int TRACE_DATA_W = 32;
    localparam int REC_W        = 2 * TRACE_DATA_W + 18;

    // Field positions (default data width)
    localparam int GAP_POS     = REC_W - 1;
    localparam int WR_POS      = REC_W - 2;
    localparam int RD_POS      = REC_W - 3;
    localparam int REGW_POS    = REC_W - 4;
    localparam int REGNUM_MSB  = REC_W - 5;
    localparam int ADDR_MSB    = 2 * TRACE_DATA_W + 8;
    localparam int MEM_MSB     = 2 * TRACE_DATA_W - 1;
    localparam int MEM_LSB     = TRACE_DATA_W;
    localparam int REGDATA_MSB = TRACE_DATA_W - 1;

    typedef struct packed {
        logic                    gap;
        logic                    wr;
        logic                    rd;
        logic                    regw;
        logic [4:0]              reg_num;
        logic [8:0]              addr;
        logic [TRACE_DATA_W-1:0] mem_data;
        logic [TRACE_DATA_W-1:0] reg_data;
    } trace_rec_t;

    function automatic int rec_width(input int data_w);
        return 2 * data_w + 18;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO holding trace records. Head data is shown combinationally
// from storage and forced to zero while empty. A write is accepted when not
// full, or when full and a pop happens in the same cycle.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int W     = 82,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [W-1:0]             wr_data,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_wr_s;
    logic          do_rd_s;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == {CW{1'b0}});
    assign count = count_q;

    // Accept/pop qualification and pointer/occupancy next-state
    always_comb begin
        do_rd_s = rd_en && !empty;
        do_wr_s = wr_en && (!full || do_rd_s);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_wr_s) begin
            wptr_d = wptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            wptr_d = wptr_q;
        end
        if (do_rd_s) begin
            rptr_d = rptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            rptr_d = rptr_q;
        end
        case ({do_wr_s, do_rd_s})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Head record, zero while empty
    always_comb begin
        if (empty) begin
            rd_data = {W{1'b0}};
        end else begin
            rd_data = mem_q[rptr_q];
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= {AW{1'b0}};
            rptr_q  <= {AW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Record storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/trace_capture.sv
// Trace capture: forms a record from each register-write / memory-access
// event, queues it in trace_fifo, and accounts for events lost to a full
// queue (drop counter, sticky overflow, gap marker on the next record).
module trace_capture
    import trace_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          clr,
    input  logic                          reg_write_sig,
    input  logic [4:0]                    reg_num,
    input  logic [DATA_W-1:0]             reg_data,
    input  logic                          wr,
    input  logic                          rd,
    input  logic [8:0]                    addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic [DATA_W-1:0]             rd_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [2*DATA_W+17:0]          out_data,
    output logic [$clog2(DEPTH):0]        count,
    output logic [15:0]                   drop_cnt,
    output logic                          overflow
);

    localparam int REC_BITS = rec_width(DATA_W);

    logic                regw_s;
    logic                evt_s;
    logic                pop_s;
    logic                push_s;
    logic                drop_s;
    logic                full_s;
    logic                empty_s;
    logic [DATA_W-1:0]   mem_data_s;
    logic [REC_BITS-1:0] rec_s;
    logic [15:0]         drop_base_s;
    logic [15:0]         drop_cnt_q, drop_cnt_d;
    logic                overflow_q, overflow_d;
    logic                gap_pend_q, gap_pend_d;

    // Event detection, accept/drop decision and record formation
    always_comb begin
        regw_s = reg_write_sig && (reg_num != 5'd0);
        evt_s  = en && (wr || rd || regw_s);
        pop_s  = !empty_s && out_ready;
        push_s = evt_s && (!full_s || pop_s);
        drop_s = evt_s && !push_s;
        if (wr) begin
            mem_data_s = wr_data;
        end else if (rd) begin
            mem_data_s = rd_data;
        end else begin
            mem_data_s = {DATA_W{1'b0}};
        end
        rec_s = {gap_pend_q, wr, rd, regw_s,
                 (regw_s ? reg_num : 5'd0),
                 ((wr || rd) ? addr : 9'd0),
                 mem_data_s,
                 (regw_s ? reg_data : {DATA_W{1'b0}})};
    end

    // Drop statistics and gap tracking; a same-cycle drop lands after clr
    always_comb begin
        if (clr) begin
            drop_base_s = 16'h0000;
        end else begin
            drop_base_s = drop_cnt_q;
        end
        if (drop_s && (drop_base_s != 16'hFFFF)) begin
            drop_cnt_d = drop_base_s + 16'h0001;
        end else begin
            drop_cnt_d = drop_base_s;
        end
        overflow_d = (clr ? 1'b0 : overflow_q) | drop_s;
        if (push_s) begin
            gap_pend_d = 1'b0;
        end else if (drop_s) begin
            gap_pend_d = 1'b1;
        end else begin
            gap_pend_d = gap_pend_q;
        end
    end

    // Statistics and gap-pending registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_q <= 16'h0000;
            overflow_q <= 1'b0;
            gap_pend_q <= 1'b0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
            gap_pend_q <= gap_pend_d;
        end
    end

    trace_fifo #(
        .W     (REC_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_s),
        .rd_en   (pop_s),
        .wr_data (rec_s),
        .rd_data (out_data),
        .full    (full_s),
        .empty   (empty_s),
        .count   (count)
    );

    assign out_valid = !empty_s;
    assign drop_cnt  = drop_cnt_q;
    assign overflow  = overflow_q;

endmodule
